// File: rtl/fc_in_stager.sv
// Input staging for the fully-connected layer: fills a register file from a
// valid/ready byte stream, holds it on x_out for SETTLE cycles, then registers z_in.
module fc_in_stager #(
  parameter int WIDTH  = 8,
  parameter int IN     = 400,
  parameter int OUT_W  = 22,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_last,
  output logic [WIDTH-1:0]  x_out [0:IN-1],
  input  logic [OUT_W-1:0]  z_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              err
);

  localparam int         IDX_W    = $clog2(IN);
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {ST_FILL, ST_SETTLE, ST_HOLD} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [3:0]         r_cnt;
  logic               r_s_ready;
  logic               r_m_valid;
  logic [OUT_W-1:0]   r_m_data;
  logic               r_err;
  logic [WIDTH-1:0]   r_mem [0:IN-1];

  logic w_hs;
  logic w_at_end;
  logic w_clear;

  assign w_hs     = (r_state == ST_FILL) && r_s_ready && s_valid;
  assign w_at_end = (r_idx == IDX_W'(IN - 1));
  assign w_clear  = (r_state == ST_HOLD) && m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_FILL;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_FILL: begin
          if (w_hs) begin
            // A frame is faulty when s_last and the final index disagree.
            r_err <= s_last ^ w_at_end;
            if (s_last || w_at_end) begin
              r_idx     <= '0;
              r_cnt     <= 4'd1;
              r_s_ready <= 1'b0;
              r_state   <= ST_SETTLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (r_cnt == SETTLE_C) begin
            r_m_data  <= z_in;
            r_m_valid <= 1'b1;
            r_state   <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_HOLD: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_state   <= ST_FILL;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  // Entries are cleared on result acceptance so a short frame leaves zeros behind.
  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      for (int i = 0; i < IN; i++) r_mem[i] <= '0;
    end else if (w_hs) begin
      r_mem[r_idx] <= s_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < IN; gi++) begin : g_xout
      assign x_out[gi] = r_mem[gi];
    end
  endgenerate

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign err     = r_err;

endmodule

// File: tb/tb_fc_in_stager.sv
// Bench for fc_in_stager: frame table plus reset and gapped-input sequences,
// checked against a frame-level model (written entries, weighted-sum result).
module tb_fc_in_stager;
  localparam int WIDTH = 8;
  localparam int IN    = 400;
  localparam int OUT_W = 22;
  localparam int S     = 2;
  localparam int S5    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             s_valid, s_ready, s_last, m_valid, m_ready, err;
  logic [WIDTH-1:0] s_data;
  logic [WIDTH-1:0] x_out [0:IN-1];
  logic [OUT_W-1:0] z_in, m_data;

  logic             s_valid5, s_ready5, s_last5, m_valid5, m_ready5, err5;
  logic [WIDTH-1:0] s_data5;
  logic [WIDTH-1:0] x_out5 [0:IN-1];
  logic [OUT_W-1:0] z_in5, m_data5;

  fc_in_stager dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .x_out(x_out), .z_in(z_in), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .err(err));

  fc_in_stager #(.SETTLE(S5)) dut5 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data5),
    .s_last(s_last5), .x_out(x_out5), .z_in(z_in5), .m_valid(m_valid5), .m_ready(m_ready5),
    .m_data(m_data5), .err(err5));

  // Stand-in for the layer: position-weighted sum of the presented vector.
  always_comb begin
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < IN; i++) acc += 32'(x_out[i]) * 32'(i % 7 + 1);
    z_in = acc[OUT_W-1:0];
  end
  always_comb begin
    logic [31:0] acc5;
    acc5 = '0;
    for (int i = 0; i < IN; i++) acc5 += 32'(x_out5[i]) * 32'(i % 7 + 1);
    z_in5 = acc5[OUT_W-1:0];
  end

  int total = 0;
  int bad   = 0;
  logic [7:0] mdl [IN];
  logic [7:0] beats [$];

  typedef struct {
    int n; bit last; int pat; bit exp_err; int hold;
  } row_t;
  row_t rows [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_x(input string name, input bit use5);
    int nb = 0;
    logic [7:0] v;
    for (int i = 0; i < IN; i++) begin
      v = use5 ? x_out5[i] : x_out[i];
      if (v !== mdl[i]) nb++;
    end
    total++;
    if (nb != 0) begin
      bad++;
      $display("FAIL %s: %0d entries differ, required 0 differing", name, nb);
    end
  endtask

  function automatic logic [63:0] wsum();
    logic [63:0] a = 0;
    for (int i = 0; i < IN; i++) a += 64'(mdl[i]) * 64'(i % 7 + 1);
    return a;
  endfunction

  task automatic clear_mdl();
    for (int i = 0; i < IN; i++) mdl[i] = 8'h00;
  endtask

  task automatic build_beats(input int n, input int pat);
    beats.delete();
    for (int i = 0; i < n; i++) begin
      case (pat)
        0:       beats.push_back(8'(i % 256));
        1:       beats.push_back(8'h7F);
        default: beats.push_back(8'($urandom_range(0, 255)));
      endcase
    end
  endtask

  // Drives one frame back-to-back, then checks err, latency, result, backpressure and release.
  task automatic run_frame(input string tag, input int n, input bit last,
                           input bit exp_err, input int hold);
    int rdy_bad = 0;
    logic [63:0] exp_sum;
    logic [OUT_W-1:0] held;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (s_ready !== 1'b1) rdy_bad++;
      s_valid = 1'b1;
      s_data  = beats[i];
      s_last  = last && (i == n - 1);
      mdl[i]  = beats[i];
    end
    exp_sum = wsum();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk({tag, "_ready_fill"}, 64'(rdy_bad), 0);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    chk({tag, "_ready_settle"}, 64'(s_ready), 0);
    chk_x({tag, "_x_settle"}, 1'b0);
    for (int c = 1; c <= S + 1; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 2) chk({tag, "_err_one_cycle"}, 64'(err), 0);
      chk({tag, "_mvalid_lat"}, 64'(m_valid), 64'(c == S + 1));
    end
    chk({tag, "_mdata"}, 64'(m_data), exp_sum);
    held = m_data;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, "_bp_mvalid"}, 64'(m_valid), 1);
      chk({tag, "_bp_mdata"}, 64'(m_data), 64'(held));
      chk({tag, "_bp_ready"}, 64'(s_ready), 0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    clear_mdl();
    chk({tag, "_rel_mvalid"}, 64'(m_valid), 0);
    chk({tag, "_rel_ready"}, 64'(s_ready), 1);
    chk_x({tag, "_rel_xzero"}, 1'b0);
    $display("frame %s: beats=%0d last=%0d m_data=%0d expected=%0d", tag, n, last, held, exp_sum);
  endtask

  initial begin
    rows[0] = '{n: 400, last: 1'b1, pat: 0, exp_err: 1'b0, hold: 0};
    rows[1] = '{n: 400, last: 1'b1, pat: 2, exp_err: 1'b0, hold: 10};
    rows[2] = '{n: 10,  last: 1'b1, pat: 1, exp_err: 1'b1, hold: 0};
    rows[3] = '{n: 400, last: 1'b0, pat: 2, exp_err: 1'b1, hold: 0};
    rows[4] = '{n: 400, last: 1'b1, pat: 2, exp_err: 1'b0, hold: 0};
    rows[5] = '{n: 1,   last: 1'b1, pat: 2, exp_err: 1'b1, hold: 3};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    s_valid5 = 1'b0; s_data5 = '0; s_last5 = 1'b0; m_ready5 = 1'b0;
    clear_mdl();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 64'(s_ready), 1);
    chk("reset_mvalid", 64'(m_valid), 0);
    chk("reset_mdata", 64'(m_data), 0);
    chk("reset_err", 64'(err), 0);
    chk_x("reset_xzero", 1'b0);

    for (int r = 0; r < 6; r++) begin
      build_beats(rows[r].n, rows[r].pat);
      run_frame($sformatf("row%0d", r), rows[r].n, rows[r].last, rows[r].exp_err, rows[r].hold);
    end

    // Reset in the middle of a frame.
    build_beats(200, 2);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = beats[i]; s_last = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_mdl();
    chk("rstmid_mvalid", 64'(m_valid), 0);
    chk_x("rstmid_xzero", 1'b0);
    @(negedge clk);
    chk("rstmid_ready", 64'(s_ready), 1);
    build_beats(400, 0);
    run_frame("after_rstmid", 400, 1'b1, 1'b0, 0);

    // Reset while a result is being held.
    build_beats(400, 2);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = beats[i]; s_last = (i == 399);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    repeat (S) @(negedge clk);
    chk("rsthold_mvalid_pre", 64'(m_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_mdl();
    chk("rsthold_mvalid", 64'(m_valid), 0);
    chk("rsthold_mdata", 64'(m_data), 0);
    chk_x("rsthold_xzero", 1'b0);
    build_beats(400, 2);
    run_frame("after_rsthold", 400, 1'b1, 1'b0, 0);

    // Gapped input on the SETTLE=5 instance.
    begin
      int i = 0;
      int cyc = 0;
      logic [63:0] exp_sum;
      bit v;
      build_beats(400, 0);
      for (int k = 0; k < IN; k++) mdl[k] = beats[k];
      exp_sum = wsum();
      while (i < IN && cyc < 5000) begin
        @(negedge clk);
        cyc++;
        v = 1'($urandom_range(0, 1));
        s_valid5 = v;
        s_data5  = v ? beats[i] : 8'($urandom_range(0, 255));
        s_last5  = (i == IN - 1);
        if (v && s_ready5) i++;
      end
      chk("gap_budget", 64'(i), 64'(IN));
      for (int c = 1; c <= S5 + 1; c++) begin
        @(negedge clk);
        if (c == 1) begin
          s_valid5 = 1'b0; s_last5 = 1'b0;
          chk("gap_err", 64'(err5), 0);
          chk_x("gap_x_settle", 1'b1);
        end
        chk("gap_mvalid_lat", 64'(m_valid5), 64'(c == S5 + 1));
      end
      chk("gap_mdata", 64'(m_data5), exp_sum);
      $display("frame gapped: cycles=%0d m_data=%0d expected=%0d", cyc, m_data5, exp_sum);
      m_ready5 = 1'b1;
      @(negedge clk);
      m_ready5 = 1'b0;
      chk("gap_rel_mvalid", 64'(m_valid5), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
